cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Memory-side responder for the pipeline's cache ports. On a cache miss it reads one 16-byte block
//  (8 x 16-bit words) from the multi-cycle backing memory, streams each returned word into the cache
//  data array, then writes the tag. It holds the requesting pipeline stage stalled through
//  fsm_busy until the fill completes. One instance serves the I-cache and one serves the D-cache.
// PARAMETERS
//  WORDS    8   words per block; power of 2; word index width = log2(WORDS)
//  AW       16  byte-address width
// PORTS
//  clk                 in   1   system clock, rising edge
//  rst_n               in   1   asynchronous, active-low reset
//  miss_detected       in   1   cache lookup missed this cycle (combinational from cache)
//  miss_address        in   AW  byte address of the missing access
//  memory_data_valid   in   1   backing memory returns a word this cycle
//  memory_data         in   16  returned word
//  fsm_busy            out  1   fill in progress; pipeline stall request
//  mem_read_en         out  1   issue a read to backing memory this cycle
//  memory_address      out  AW  address of the issued read
//  write_data_array    out  1   write fill_data into the cache data array at fill_address
//  fill_address        out  AW  byte address of the word being written
//  fill_data           out  16  word written to the data array (= memory_data)
//  write_tag_array     out  1   one-cycle pulse that writes tag/valid for the block at fill_address
// BEHAVIOUR
//  - States: IDLE, FILL. Reset (async, rst_n=0): state=IDLE, issue_cnt=0, ret_cnt=0, base=0.
//    All outputs are 0 during and immediately after reset.
//  - base = {miss_address[AW-1:4], 4'b0}. It is latched on the IDLE->FILL edge and is stable for
//    the whole fill. Changes to miss_address during FILL are ignored.
//  - IDLE: fsm_busy = miss_detected (combinational, so the stall lands in the miss cycle).
//    If miss_detected=1, go to FILL at the next edge. No reads are issued in IDLE.
//  - FILL, issue side: mem_read_en=1 while issue_cnt<WORDS.
//    memory_address = base + 2*issue_cnt; issue_cnt increments by 1 per cycle.
//    At most one issue per cycle, with no gaps between issues.
//  - FILL, return side: when memory_data_valid=1, write_data_array=1,
//    fill_address = base + 2*ret_cnt, fill_data = memory_data, and ret_cnt increments.
//    Words are assumed to return in issue order.
//  - Completion: a valid word with ret_cnt==WORDS-1 also pulses write_tag_array in the same cycle.
//    fill_address carries the last word's address, which the tag array decodes by index.
//    Next state is IDLE; counters clear to 0.
//  - fsm_busy=1 for every FILL cycle, including the final write cycle. It drops in the next cycle.
//  - Issue and return may occur in the same cycle; the two counters are independent.
//  - memory_data_valid while in IDLE is ignored: no array writes occur.
//  - miss_detected during FILL is ignored. A still-pending miss re-evaluates in IDLE and normally
//    hits after the fill.
//  - A miss asserted in the very cycle FILL returns to IDLE is accepted on the next IDLE cycle.
//  - Reset mid-fill: the fill is abandoned immediately. The tag is never written, so the partial
//    block stays invalid. Late memory_data_valid after reset is ignored in IDLE.
//  - Counters are log2(WORDS)+1 bits wide, so WORDS does not wrap. Address arithmetic is modulo
//    2^AW; a block at 0xFFF0 issues addresses up to 0xFFFE without overflow.
//  - fill_data/fill_address/memory_address are don't-care when their strobes are low.
//    They drive 0 so that waveforms stay clean.
// STRUCTURE
//  - Shared package: WORDS, block offset width (4), state encoding {IDLE=1'b0, FILL=1'b1}.
//  - One sub-module: fill_counter (width-parameterised up-counter with enable and sync clear,
//    async active-low reset), instantiated twice for issue_cnt and ret_cnt.
//  - State register plus next-state/output logic live in this module.
// TESTING
//  1 Reset then idle: rst_n=0 for 2 cycles, no miss -> all outputs 0. Stray
//    memory_data_valid=1 -> no write_data_array.
//  2 Single fill: miss at 0x1236 in cycle 0 -> fsm_busy=1 in cycle 0. mem_read_en cycles 1-8 with
//    addresses 0x1230..0x123E step 2. With a 4-cycle memory, writes occur in cycles 5-12 at
//    0x1230..0x123E. write_tag_array=1 only in cycle 12; fsm_busy=0 in cycle 13.
//  3 miss_address changes to 0x8000 in cycle 3 -> issued/fill addresses stay in 0x1230 block;
//    miss_detected held through fill -> no second fill starts until IDLE.
//  4 Back-to-back misses: 0x0040 then 0xFFF0 immediately -> second fill starts the cycle after
//    the first tag write; last address 0xFFFE, no wrap.
//  5 Reset mid-fill: rst_n=0 in cycle 7 of test 2 -> outputs 0 at once, write_tag_array never
//    asserted. Following valids are ignored.
//  6 Irregular returns: valid gaps (returns at cycles 5, 9, 10, 15, ...) -> ret_cnt advances only on
//    valid; tag pulses on the 8th word only.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm_pkg
//   Shared constants and the state encoding for the cache block fill engine.
//   FILL_WORDS : 16-bit words per cache block
//   BLK_OFF_W  : byte-offset width of one block (16 bytes)
//   state_e    : IDLE waits for a miss, FILL issues reads and writes returns
// -----------------------------------------------------------------------------
package cache_fill_fsm_pkg;

    localparam int FILL_WORDS = 8;
    localparam int BLK_OFF_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// -----------------------------------------------------------------------------
// fill_counter
//   Up-counter with enable and synchronous clear. Clear wins over enable.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   en         : increment this cycle
//   clr        : synchronous clear to 0
//   cnt        : current count
// -----------------------------------------------------------------------------
module fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//   Memory-side responder for one cache port. On a miss it reads the whole
//   16-byte block from backing memory, streams every returned word into the
//   data array and pulses the tag write alongside the last word.
//   miss_detected/miss_address       : miss from the cache lookup (comb.)
//   memory_data_valid/memory_data    : in-order word return from memory
//   fsm_busy                         : pipeline stall request
//   mem_read_en/memory_address       : one read issue per cycle
//   write_data_array/fill_address/
//   fill_data                        : data array write port
//   write_tag_array                  : tag/valid write, one-cycle pulse
// -----------------------------------------------------------------------------
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int WORDS = FILL_WORDS,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          miss_detected,
    input  logic [AW-1:0] miss_address,
    input  logic          memory_data_valid,
    input  logic [15:0]   memory_data,
    output logic          fsm_busy,
    output logic          mem_read_en,
    output logic [AW-1:0] memory_address,
    output logic          write_data_array,
    output logic [AW-1:0] fill_address,
    output logic [15:0]   fill_data,
    output logic          write_tag_array
);

    // One extra bit so the issue counter can sit at WORDS once all reads are out.
    localparam int CW = $clog2(WORDS) + 1;

    localparam logic [AW-1:0] BLK_MASK =
        ~{{(AW-BLK_OFF_W){1'b0}}, {BLK_OFF_W{1'b1}}};

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] issue_cnt, ret_cnt;
    logic          issue_en, ret_en, fill_done;
    logic [AW-1:0] issue_off, ret_off;

    always_comb begin
        issue_en  = (state_q == FILL) && (issue_cnt < CW'(WORDS));
        ret_en    = (state_q == FILL) && memory_data_valid;
        fill_done = ret_en && (ret_cnt == CW'(WORDS - 1));
        // Word index -> byte offset (16-bit words).
        issue_off = AW'({issue_cnt, 1'b0});
        ret_off   = AW'({ret_cnt, 1'b0});

        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d = FILL;
                    base_d  = miss_address & BLK_MASK;
                end
            end
            FILL: begin
                if (fill_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    fill_counter #(.W(CW)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue_en),
        .clr   (fill_done),
        .cnt   (issue_cnt)
    );

    fill_counter #(.W(CW)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ret_en),
        .clr   (fill_done),
        .cnt   (ret_cnt)
    );

    always_comb begin
        // Stall in the miss cycle itself; the rst_n term keeps it low while
        // reset is held even if the cache still reports a miss.
        fsm_busy         = (state_q == FILL) || (rst_n && miss_detected);
        mem_read_en      = issue_en;
        memory_address   = issue_en ? base_q + issue_off : '0;
        write_data_array = ret_en;
        fill_address     = ret_en ? base_q + ret_off : '0;
        fill_data        = ret_en ? memory_data : '0;
        write_tag_array  = fill_done;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = '0;
    logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
    logic [15:0] memory_address, fill_address, fill_data;

    always #5 clk = ~clk;

    cache_fill_fsm #(.WORDS(8), .AW(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_address      (fill_address),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    typedef struct { logic [15:0] a; int rdy; } mreq_t;
    typedef struct { logic [15:0] a; logic [15:0] d; logic tag; } exp_t;
    typedef struct {
        logic [15:0] miss; logic [15:0] exp_base; logic [15:0] exp_last;
        int lat; logic [31:0] gaps; int exp_tag;
    } vec_t;

    mreq_t mq[$];
    exp_t  sb[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, cyc0 = 0, lat = 4, tag_cyc = -1, tag_cnt = 0;
    logic [31:0] gap_mask = '0;
    logic drv_rst = 1'b1, drv_miss = 1'b0, drv_stray = 1'b0;
    logic [15:0] drv_addr = '0;
    logic got_first = 1'b0;
    logic [15:0] first_iss = '0, last_iss = '0;

    // Reference model state
    logic m_fill = 1'b0;
    logic [15:0] m_base = '0;
    int m_iss = 0, m_ret = 0;

    function automatic logic [15:0] wdata(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        logic v, eb, er, etag;
        logic [15:0] d;
        int rel;
        exp_t e;
        @(posedge clk); #1;
        cyc++;
        rel = cyc - cyc0;
        rst_n = !drv_rst;
        if (drv_rst) begin
            m_fill = 1'b0; m_iss = 0; m_ret = 0; sb.delete();
        end
        miss_detected = drv_miss;
        miss_address  = drv_addr;
        v = 1'b0; d = '0;
        if (drv_stray) begin
            v = 1'b1; d = 16'h5A5A;
        end else if (mq.size() > 0 && mq[0].rdy <= cyc &&
                     !(rel >= 0 && rel < 32 && gap_mask[rel])) begin
            d = wdata(mq[0].a);
            void'(mq.pop_front());
            v = 1'b1;
        end
        memory_data_valid = v;
        memory_data = d;
        etag = v && m_fill && (m_ret == 7);
        if (v && m_fill) sb.push_back('{m_base + 16'(2 * m_ret), d, etag});

        @(negedge clk);
        eb = !drv_rst && (m_fill || drv_miss);
        er = m_fill && (m_iss < 8);
        chk("fsm_busy", {31'b0, fsm_busy}, {31'b0, eb});
        chk("mem_read_en", {31'b0, mem_read_en}, {31'b0, er});
        chk("memory_address", {16'b0, memory_address}, {16'b0, er ? m_base + 16'(2 * m_iss) : 16'h0});
        chk("write_data_array", {31'b0, write_data_array}, {31'b0, v && m_fill});
        chk("write_tag_array", {31'b0, write_tag_array}, {31'b0, etag});
        if (write_data_array && sb.size() > 0) begin
            e = sb.pop_front();
            chk("fill_address", {16'b0, fill_address}, {16'b0, e.a});
            chk("fill_data", {16'b0, fill_data}, {16'b0, e.d});
        end
        if (sb.size() > 0) begin
            chk("missing_write", sb.size(), 0);
            sb.delete();
        end
        if (write_tag_array) begin
            tag_cyc = cyc; tag_cnt++;
        end
        if (mem_read_en) begin
            mq.push_back('{memory_address, cyc + lat});
            if (!got_first) begin first_iss = memory_address; got_first = 1'b1; end
            last_iss = memory_address;
        end
        if (!drv_rst) begin
            if (!m_fill) begin
                if (drv_miss) begin m_fill = 1'b1; m_base = {drv_addr[15:4], 4'h0}; end
            end else begin
                if (er) m_iss++;
                if (v) begin
                    if (m_ret == 7) begin m_fill = 1'b0; m_iss = 0; m_ret = 0; end
                    else m_ret++;
                end
            end
        end
    endtask

    task automatic start(input logic [15:0] a, input int l);
        lat = l; cyc0 = cyc + 1; tag_cyc = -1; got_first = 1'b0;
        drv_miss = 1'b1; drv_addr = a;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mq.size() > 0; i++) cycle();
        chk("mem_drained", mq.size(), 0);
        mq.delete();
        gap_mask = '0;
        cycle();
    endtask

    vec_t vt[5];
    int tc0;

    initial begin
        vt[0] = '{16'h1236, 16'h1230, 16'h123E, 4, 32'h0000_0000, 12};
        vt[1] = '{16'h0040, 16'h0040, 16'h004E, 1, 32'h0000_0000, 9};
        vt[2] = '{16'hFFF0, 16'hFFF0, 16'hFFFE, 2, 32'h0000_0000, 10};
        vt[3] = '{16'hABCD, 16'hABC0, 16'hABCE, 4, 32'h0000_79C0, 19};
        vt[4] = '{16'h0007, 16'h0000, 16'h000E, 3, 32'hAAAA_AAAA, 18};

        // Reset, then idle with stray returns
        drv_rst = 1'b1; cycle(); cycle();
        chk("reset_busy", {31'b0, fsm_busy}, 0);
        drv_rst = 1'b0; cycle();
        drv_stray = 1'b1; cycle();
        chk("stray_write", {31'b0, write_data_array}, 0);
        cycle(); drv_stray = 1'b0; cycle();

        // Table-driven single fills
        for (int k = 0; k < 5; k++) begin
            start(vt[k].miss, vt[k].lat);
            gap_mask = vt[k].gaps;
            cycle();
            drv_miss = 1'b0;
            for (int i = 0; i < 60 && tag_cyc < 0; i++) cycle();
            chk("tag_cycle", tag_cyc - cyc0, vt[k].exp_tag);
            chk("first_issue", {16'b0, first_iss}, {16'b0, vt[k].exp_base});
            chk("last_issue", {16'b0, last_iss}, {16'b0, vt[k].exp_last});
            cycle();
            chk("busy_drop", {31'b0, fsm_busy}, 0);
            drain();
        end

        // miss_address moves mid-fill and miss stays asserted throughout
        start(16'h1236, 4);
        cycle();
        for (int i = 0; i < 60 && tag_cyc < 0; i++) begin
            if (cyc + 1 - cyc0 == 3) drv_addr = 16'h8000;
            cycle();
        end
        chk("held_tag_cycle", tag_cyc - cyc0, 12);
        chk("held_last_issue", {16'b0, last_iss}, 16'h123E);
        drv_miss = 1'b0; cycle();
        chk("held_busy_drop", {31'b0, fsm_busy}, 0);
        drain();

        // Back-to-back: second miss raised in the final write cycle
        start(16'h0040, 1);
        cycle();
        drv_miss = 1'b0;
        for (int i = 0; i < 30 && tag_cyc < 0; i++) begin
            if (cyc + 1 - cyc0 == 9) begin drv_miss = 1'b1; drv_addr = 16'hFFF0; end
            cycle();
        end
        chk("b2b_first_tag", tag_cyc - cyc0, 9);
        tag_cyc = -1; got_first = 1'b0;
        cycle();
        drv_miss = 1'b0;
        chk("b2b_idle_busy", {31'b0, fsm_busy}, 1);
        chk("b2b_idle_rd", {31'b0, mem_read_en}, 0);
        for (int i = 0; i < 30 && tag_cyc < 0; i++) cycle();
        chk("b2b_second_tag", tag_cyc - cyc0, 19);
        chk("b2b_first_issue", {16'b0, first_iss}, 16'hFFF0);
        chk("b2b_last_issue", {16'b0, last_iss}, 16'hFFFE);
        drain();

        // Reset in cycle 7 of a fill
        start(16'h1236, 4);
        cycle();
        drv_miss = 1'b0;
        for (int i = 1; i < 7; i++) cycle();
        tc0 = tag_cnt;
        drv_rst = 1'b1; cycle();
        chk("rst_busy", {31'b0, fsm_busy}, 0);
        chk("rst_rd", {31'b0, mem_read_en}, 0);
        cycle();
        drv_rst = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        chk("rst_no_tag", tag_cnt, tc0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
